// File: rtl/data_mem_sequencer.sv
// Multi-cycle LW/SW/LB/SB sequencer between the execute stage and a
// handshaked word-addressed data memory; SB is done as read-modify-write.
module data_mem_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] OP_LW = 2'b00;
  localparam logic [1:0] OP_SW = 2'b01;
  localparam logic [1:0] OP_LB = 2'b10;
  localparam logic [1:0] OP_SB = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ     = 3'd1,
    S_RMW_READ = 3'd2,
    S_WRITE    = 3'd3,
    S_RESP     = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               timeout;
  logic               err_q, err_d;
  logic [1:0]         op_q, op_d;
  logic [1:0]         byte_q, byte_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [7:0]         rd_byte;
  logic [31:0]        lb_word;
  logic [31:0]        merge_word;

  // Byte lane extraction (LB) and lane replacement (SB) for the latched offset
  always_comb begin
    rd_byte    = mem_rdata[{byte_q, 3'b000} +: 8];
    lb_word    = {{24{rd_byte[7]}}, rd_byte};
    merge_word = mem_rdata;
    merge_word[{byte_q, 3'b000} +: 8] = mem_wdata_q[7:0];
  end

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign timeout = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      op_q        <= OP_LW;
      byte_q      <= 2'b00;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      op_q        <= op_d;
      byte_q      <= byte_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    op_d        = op_q;
    byte_d      = byte_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d        = op;
          byte_d      = addr[1:0];
          mem_addr_d  = {addr[31:2], 2'b00};
          mem_wdata_d = wdata;
          err_d       = 1'b0;
          cnt_d       = '0;
          // Word ops must be aligned; byte ops accept any offset
          if (!op[1] && (addr[1:0] != 2'b00)) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            unique case (op)
              OP_LW, OP_LB: state_d = S_READ;
              OP_SW:        state_d = S_WRITE;
              OP_SB:        state_d = S_RMW_READ;
              default:      state_d = S_IDLE;
            endcase
          end
        end
      end

      S_READ: begin
        if (mem_ack) begin
          rdata_d = (op_q == OP_LB) ? lb_word : mem_rdata;
          state_d = S_RESP;
        end else if (timeout) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_RMW_READ: begin
        if (mem_ack) begin
          mem_wdata_d = merge_word;
          cnt_d       = '0;
          state_d     = S_WRITE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_WRITE: begin
        if (mem_ack) begin
          state_d = S_RESP;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state only
  always_comb begin
    busy    = (state_q != S_IDLE);
    mem_req = (state_q == S_READ) || (state_q == S_RMW_READ) || (state_q == S_WRITE);
    mem_we  = (state_q == S_WRITE);
    done    = (state_q == S_RESP);
    err     = (state_q == S_RESP) && err_q;
  end

  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_sequencer.sv
// Directed bench for data_mem_sequencer with a small handshaking memory
// responder and hand-computed expected results.
module tb_data_mem_sequencer;

  localparam logic [1:0] OP_LW = 2'b00;
  localparam logic [1:0] OP_SW = 2'b01;
  localparam logic [1:0] OP_LB = 2'b10;
  localparam logic [1:0] OP_SB = 2'b11;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        start;
  logic [1:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  bit          ack_en   = 1'b1;
  int          ack_wait = 0;
  int          req_cyc  = 0;
  int          req_hi   = 0;
  logic [31:0] mem_word = '0;
  logic [31:0] log_addr[$];
  logic [31:0] log_wdata[$];
  logic        log_we[$];

  int          cyc;
  logic        e;
  logic [31:0] rd;

  data_mem_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .start     (start),
    .op        (op),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem_word;

  // Memory responder: acks after ack_wait request cycles, logs each accepted transfer
  always @(negedge clk) begin
    if (!mem_req) begin
      mem_ack = 1'b0;
      req_cyc = 0;
    end else begin
      req_hi++;
      if (ack_en && req_cyc == ack_wait) begin
        mem_ack = 1'b1;
        req_cyc = 0;
        log_addr.push_back(mem_addr);
        log_wdata.push_back(mem_wdata);
        log_we.push_back(mem_we);
      end else begin
        mem_ack = 1'b0;
        req_cyc++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    req_hi = 0;
    log_addr.delete();
    log_wdata.delete();
    log_we.delete();
  endtask

  // Issue one request, scramble the inputs afterwards, count cycles to done
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] w,
                        output int c, output logic er, output logic [31:0] r);
    @(negedge clk);
    start = 1'b1; op = o; addr = a; wdata = w;
    clear_log();
    @(negedge clk);
    start = 1'b0; op = ~o; addr = 32'hFFFF_FFFF; wdata = ~w;
    c = 1;
    while (!done && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("done_seen", 32'(done), 32'd1);
    er = err;
    r  = rdata;
  endtask

  initial begin
    rst_b = 1'b0; start = 1'b0; op = OP_LW; addr = '0; wdata = '0; mem_ack = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    check("rst_req_we", {30'd0, mem_req, mem_we}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;

    // LW with two wait cycles
    ack_wait = 2; mem_word = 32'hDEADBEEF;
    run_op(OP_LW, 32'h10, 32'h0, cyc, e, rd);
    check("lw_latency", 32'(cyc), 32'd4);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_err", 32'(e), 32'd0);
    check("lw_req_cycles", 32'(req_hi), 32'd3);
    check("lw_log_n", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() == 1) begin
      check("lw_mem_addr", log_addr[0], 32'h10);
      check("lw_mem_we", 32'(log_we[0]), 32'd0);
    end
    @(negedge clk);
    check("lw_done_pulse", 32'(done), 32'd0);
    check("lw_rdata_held", rdata, 32'hDEADBEEF);

    // LB sign- and zero-extension
    ack_wait = 0; mem_word = 32'h80FF1234;
    run_op(OP_LB, 32'h13, 32'h0, cyc, e, rd);
    check("lb3_rdata", rd, 32'hFFFFFF80);
    check("lb3_latency", 32'(cyc), 32'd2);
    if (log_addr.size() == 1) check("lb3_mem_addr", log_addr[0], 32'h10);
    run_op(OP_LB, 32'h11, 32'h0, cyc, e, rd);
    check("lb1_rdata", rd, 32'h00000012);
    check("lb1_err", 32'(e), 32'd0);

    // SB read-modify-write
    mem_word = 32'h11223344;
    run_op(OP_SB, 32'h22, 32'h000000AB, cyc, e, rd);
    check("sb_latency", 32'(cyc), 32'd3);
    check("sb_err", 32'(e), 32'd0);
    check("sb_rdata_kept", rd, 32'h00000012);
    check("sb_log_n", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() == 2) begin
      check("sb_rd_addr", log_addr[0], 32'h20);
      check("sb_rd_we", 32'(log_we[0]), 32'd0);
      check("sb_wr_addr", log_addr[1], 32'h20);
      check("sb_wr_we", 32'(log_we[1]), 32'd1);
      check("sb_wr_data", log_wdata[1], 32'h11AB3344);
    end

    // Misaligned word ops: error without memory access
    run_op(OP_SW, 32'h06, 32'h55555555, cyc, e, rd);
    check("sw_mis_latency", 32'(cyc), 32'd1);
    check("sw_mis_err", 32'(e), 32'd1);
    check("sw_mis_req", 32'(req_hi), 32'd0);
    check("sw_mis_rdata", rd, 32'h00000012);
    run_op(OP_LW, 32'h02, 32'h0, cyc, e, rd);
    check("lw_mis_err", 32'(e), 32'd1);
    check("lw_mis_req", 32'(req_hi), 32'd0);

    // Aligned SW
    run_op(OP_SW, 32'h24, 32'hA5A5_0F0F, cyc, e, rd);
    check("sw_latency", 32'(cyc), 32'd2);
    if (log_addr.size() == 1) check("sw_wr_data", log_wdata[0], 32'hA5A5_0F0F);
    check("sw_rdata_kept", rd, 32'h00000012);

    // LW timeout with no ack
    ack_en = 1'b0;
    run_op(OP_LW, 32'h40, 32'h0, cyc, e, rd);
    check("to_req_cycles", 32'(req_hi), 32'd8);
    check("to_latency", 32'(cyc), 32'd9);
    check("to_err", 32'(e), 32'd1);
    check("to_rdata", rd, 32'd0);
    check("to_mem_req", 32'(mem_req), 32'd0);
    ack_en = 1'b1;

    // Start pulses during WRITE and during RESP are ignored
    ack_wait = 3;
    @(negedge clk);
    start = 1'b1; op = OP_SW; addr = 32'h30; wdata = 32'hCAFEF00D;
    clear_log();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = OP_LW; addr = 32'h40;
    @(negedge clk);
    start = 1'b0;
    cyc = 3;
    while (!done && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("stall_latency", 32'(cyc), 32'd5);
    start = 1'b1; op = OP_LW; addr = 32'h44;
    @(negedge clk);
    start = 1'b0;
    check("stall_resp_start", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("stall_idle", 32'(busy), 32'd0);
    check("stall_req_cycles", 32'(req_hi), 32'd4);
    check("stall_log_n", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() == 1) begin
      check("stall_wr_addr", log_addr[0], 32'h30);
      check("stall_wr_data", log_wdata[0], 32'hCAFEF00D);
      check("stall_wr_we", 32'(log_we[0]), 32'd1);
    end

    // Asynchronous reset mid-WRITE
    ack_wait = 10;
    @(negedge clk);
    start = 1'b1; op = OP_SW; addr = 32'h50; wdata = 32'h1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_rst_req", 32'(mem_req), 32'd1);
    #2 rst_b = 1'b0;
    #1;
    check("async_rst_req", 32'(mem_req), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_rdata", rdata, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;

    // Normal LW after reset release
    ack_wait = 0; mem_word = 32'h12345678;
    run_op(OP_LW, 32'h10, 32'h0, cyc, e, rd);
    check("post_rst_latency", 32'(cyc), 32'd2);
    check("post_rst_rdata", rd, 32'h12345678);
    check("post_rst_err", 32'(e), 32'd0);
    if (log_addr.size() == 1) check("post_rst_addr", log_addr[0], 32'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
